// File: rtl/sb_pkg.sv
// Store buffer shared types and helpers.
//   SB_ADDR_W   : default byte address width
//   SB_WADDR_W  : word address width kept per entry
//   sb_entry_t  : one buffer entry {valid, waddr, be, data}
//   sb_bd_t     : byte-enable/data pair returned by sb_merge
//   sb_merge()  : folds a newer byte-enabled write into an older one
package sb_pkg;

   localparam int unsigned SB_ADDR_W  = 32;
   localparam int unsigned SB_WADDR_W = SB_ADDR_W - 2;

   typedef struct packed {
      logic                  valid;
      logic [SB_WADDR_W-1:0] waddr;
      logic [3:0]            be;
      logic [31:0]           data;
   } sb_entry_t;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] data;
   } sb_bd_t;

   // Newer bytes win; enables accumulate.
   function automatic sb_bd_t sb_merge(input logic [3:0]  old_be,
                                       input logic [31:0] old_data,
                                       input logic [3:0]  new_be,
                                       input logic [31:0] new_data);
      sb_bd_t res;
      res.be = old_be | new_be;
      for (int i = 0; i < 4; i++) begin
         res.data[8*i +: 8] = new_be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/store_buffer.sv
// Store buffer between the MEM-stage store aligner and the single-port data RAM.
// Queues byte-enabled word stores, merges back-to-back stores to the youngest
// word, drains one entry per cycle when no load needs the RAM port, and flags
// loads that hit a pending word.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   st_valid_i/st_addr_i/st_we4_i/st_data4_i : store request (byte address, enables, data)
//   st_ready_o              : store accepted this cycle (low = MEM stage holds request)
//   ld_valid_i/ld_addr_i    : load request in MEM stage
//   ld_hazard_o             : load word is pending in the buffer
//   mem_we4_o/mem_addr_o/mem_wdata_o : RAM write port (we4 = 0 means no write)
//   empty_o                 : no pending entries
// ADDR_WIDTH must match sb_pkg::SB_ADDR_W since entries are typed from the package.
module store_buffer
   import sb_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = SB_ADDR_W,
   // Clear when ld_valid_i is driven independently of the MEM-stage op decode.
   parameter bit          CheckOneOp = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  st_valid_i,
   input  logic [ADDR_WIDTH-1:0] st_addr_i,
   input  logic [3:0]            st_we4_i,
   input  logic [31:0]           st_data4_i,
   output logic                  st_ready_o,
   input  logic                  ld_valid_i,
   input  logic [ADDR_WIDTH-1:0] ld_addr_i,
   output logic                  ld_hazard_o,
   output logic [3:0]            mem_we4_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic                  empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   sb_entry_t             entries_q [DEPTH];
   sb_entry_t             entries_d [DEPTH];
   logic [PtrW-1:0]       head_q, head_d;
   logic [PtrW-1:0]       tail_q, tail_d;
   logic [CntW-1:0]       count_q, count_d;

   logic [SB_WADDR_W-1:0] st_waddr;
   logic [SB_WADDR_W-1:0] ld_waddr;
   logic [PtrW-1:0]       young_idx;
   logic [DEPTH-1:0]      ld_hit;
   logic                  drain;
   logic                  merge_ok;
   logic                  st_fire;
   logic                  do_merge;
   logic                  do_push;
   sb_bd_t                merged;
   logic                  unused_addr_lsbs;

   assign unused_addr_lsbs = ^{st_addr_i[1:0], ld_addr_i[1:0]};

   always_comb begin
      st_waddr  = st_addr_i[ADDR_WIDTH-1:2];
      ld_waddr  = ld_addr_i[ADDR_WIDTH-1:2];
      young_idx = tail_q - PtrW'(1);

      // A draining entry still counts: the RAM is only written at the edge.
      for (int i = 0; i < DEPTH; i++) begin
         ld_hit[i] = entries_q[i].valid && (entries_q[i].waddr == ld_waddr);
      end
      ld_hazard_o = ld_valid_i && (|ld_hit);

      // A stalled load must not hold the port, or its hazard could never clear.
      drain = (count_q != '0) && (!ld_valid_i || ld_hazard_o);

      // With a single entry the youngest is the head; never merge into a draining entry.
      merge_ok = (count_q != '0) && (entries_q[young_idx].waddr == st_waddr) &&
                 !(drain && (count_q == CntW'(1)));

      // Ignores a same-cycle drain on purpose: no fall-through when full.
      st_ready_o = (count_q < CntW'(DEPTH)) || merge_ok;

      st_fire  = st_valid_i && (st_we4_i != 4'b0000) && st_ready_o;
      do_merge = st_fire && merge_ok;
      do_push  = st_fire && !merge_ok;

      merged = sb_merge(entries_q[young_idx].be, entries_q[young_idx].data,
                        st_we4_i, st_data4_i);

      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;

      if (drain) begin
         entries_d[head_q].valid = 1'b0;
         head_d                  = head_q + PtrW'(1);
      end
      if (do_merge) begin
         entries_d[young_idx].be   = merged.be;
         entries_d[young_idx].data = merged.data;
      end
      if (do_push) begin
         entries_d[tail_q].valid = 1'b1;
         entries_d[tail_q].waddr = st_waddr;
         entries_d[tail_q].be    = st_we4_i;
         entries_d[tail_q].data  = st_data4_i;
         tail_d                  = tail_q + PtrW'(1);
      end

      unique case ({do_push, drain})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      mem_we4_o   = drain ? entries_q[head_q].be : 4'b0000;
      mem_addr_o  = {entries_q[head_q].waddr, 2'b00};
      mem_wdata_o = entries_q[head_q].data;
      empty_o     = (count_q == '0);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   if (CheckOneOp) begin : g_one_op_check
      // Only one MEM op per cycle; the store side would win if both appear.
      a_one_op : assert property (@(posedge clk_i) disable iff (reset_i)
                                  !(st_valid_i && ld_valid_i))
         else $error("store and load requested in the same cycle");
   end

endmodule
